bp_cfg_param_responder: RTL and testbench

- Runtime read-side responder for the static processor parameter table; one instance per config domain.
- Selects one bp_proc_param_s entry from all_cfgs_gp at elaboration and serves its fields by numeric field ID over a valid/ready request and valid/yumi response handshake.
- Supports a single-field read, and a dump that streams every field from a start ID to the last field.
- Used by boot firmware and debug to discover the core geometry.

---
 rtl/bp_common_aviary_pkg.sv | 154 +++++++++++++++
 rtl/bp_cfg_field_mux.sv | 70 +++++++
 rtl/bp_cfg_param_responder.sv | 127 ++++++++++++
 tb/tb_bp_cfg_param_responder.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_common_aviary_pkg.sv
// Shared processor parameter table and config-responder types.
// Each config is one bp_proc_param_s entry in all_cfgs_gp, indexed by bp_params_e.
package bp_common_aviary_pkg;

  typedef enum logic [1:0] {
    e_bp_inv_cfg         = 2'd0,
    e_bp_single_core_cfg = 2'd1,
    e_bp_dual_core_cfg   = 2'd2
  } bp_params_e;

  localparam int bp_num_cfgs_gp = 3;

  // Member order defines the numeric field IDs served by bp_cfg_field_mux.
  typedef struct packed {
    int unsigned num_core;
    int unsigned cc_x_dim;
    int unsigned cc_y_dim;
    int unsigned num_io;
    int unsigned num_cce;
    int unsigned num_lce;
    int unsigned asid_width;
    int unsigned vaddr_width;
    int unsigned paddr_width;
    int unsigned branch_metadata_fwd_width;
    int unsigned btb_tag_width;
    int unsigned btb_idx_width;
    int unsigned bht_idx_width;
    int unsigned ghist_width;
    int unsigned itlb_els;
    int unsigned dtlb_els;
    int unsigned cce_pc_width;
    int unsigned lce_sets;
    int unsigned lce_assoc;
    int unsigned cce_block_width;
    int unsigned fe_queue_fifo_els;
    int unsigned fe_cmd_fifo_els;
    int unsigned async_coh_clk;
    int unsigned coh_noc_max_credits;
    int unsigned coh_noc_cord_width;
    int unsigned coh_noc_cid_width;
    int unsigned coh_noc_len_width;
    int unsigned coh_noc_flit_width;
    int unsigned async_mem_clk;
    int unsigned mem_noc_max_credits;
    int unsigned mem_noc_cord_width;
    int unsigned mem_noc_flit_width;
    int unsigned mem_noc_did_width;
    int unsigned mem_noc_len_width;
  } bp_proc_param_s;

  localparam bp_proc_param_s bp_inv_cfg_p = '0;

  localparam bp_proc_param_s bp_single_core_cfg_p = '{
    num_core                  : 1,
    cc_x_dim                  : 1,
    cc_y_dim                  : 1,
    num_io                    : 1,
    num_cce                   : 1,
    num_lce                   : 2,
    asid_width                : 10,
    vaddr_width               : 39,
    paddr_width               : 40,
    branch_metadata_fwd_width : 36,
    btb_tag_width             : 9,
    btb_idx_width             : 6,
    bht_idx_width             : 9,
    ghist_width               : 2,
    itlb_els                  : 8,
    dtlb_els                  : 8,
    cce_pc_width              : 8,
    lce_sets                  : 64,
    lce_assoc                 : 8,
    cce_block_width           : 512,
    fe_queue_fifo_els         : 8,
    fe_cmd_fifo_els           : 4,
    async_coh_clk             : 0,
    coh_noc_max_credits       : 8,
    coh_noc_cord_width        : 4,
    coh_noc_cid_width         : 2,
    coh_noc_len_width         : 3,
    coh_noc_flit_width        : 62,
    async_mem_clk             : 0,
    mem_noc_max_credits       : 8,
    mem_noc_cord_width        : 4,
    mem_noc_flit_width        : 30,
    mem_noc_did_width         : 3,
    mem_noc_len_width         : 5
  };

  // Widens a base config along x; every core brings one CCE and two LCEs.
  function automatic bp_proc_param_s bp_scale_cc_x(bp_proc_param_s base, int unsigned x_dim);
    bp_proc_param_s cfg;
    cfg          = base;
    cfg.cc_x_dim = x_dim;
    cfg.num_core = x_dim * base.cc_y_dim;
    cfg.num_cce  = cfg.num_core;
    cfg.num_lce  = 2 * cfg.num_core;
    return cfg;
  endfunction

  localparam bp_proc_param_s bp_dual_core_cfg_p = bp_scale_cc_x(bp_single_core_cfg_p, 2);

  localparam bp_proc_param_s [bp_num_cfgs_gp-1:0] all_cfgs_gp = {
    bp_dual_core_cfg_p,
    bp_single_core_cfg_p,
    bp_inv_cfg_p
  };

  localparam int bp_cfg_num_fields_gp = 34;

  typedef enum logic [5:0] {
    e_field_num_core                  = 6'd0,
    e_field_cc_x_dim                  = 6'd1,
    e_field_cc_y_dim                  = 6'd2,
    e_field_num_io                    = 6'd3,
    e_field_num_cce                   = 6'd4,
    e_field_num_lce                   = 6'd5,
    e_field_asid_width                = 6'd6,
    e_field_vaddr_width               = 6'd7,
    e_field_paddr_width               = 6'd8,
    e_field_branch_metadata_fwd_width = 6'd9,
    e_field_btb_tag_width             = 6'd10,
    e_field_btb_idx_width             = 6'd11,
    e_field_bht_idx_width             = 6'd12,
    e_field_ghist_width               = 6'd13,
    e_field_itlb_els                  = 6'd14,
    e_field_dtlb_els                  = 6'd15,
    e_field_cce_pc_width              = 6'd16,
    e_field_lce_sets                  = 6'd17,
    e_field_lce_assoc                 = 6'd18,
    e_field_cce_block_width           = 6'd19,
    e_field_fe_queue_fifo_els         = 6'd20,
    e_field_fe_cmd_fifo_els           = 6'd21,
    e_field_async_coh_clk             = 6'd22,
    e_field_coh_noc_max_credits       = 6'd23,
    e_field_coh_noc_cord_width        = 6'd24,
    e_field_coh_noc_cid_width         = 6'd25,
    e_field_coh_noc_len_width         = 6'd26,
    e_field_coh_noc_flit_width        = 6'd27,
    e_field_async_mem_clk             = 6'd28,
    e_field_mem_noc_max_credits       = 6'd29,
    e_field_mem_noc_cord_width        = 6'd30,
    e_field_mem_noc_flit_width        = 6'd31,
    e_field_mem_noc_did_width         = 6'd32,
    e_field_mem_noc_len_width         = 6'd33
  } bp_cfg_field_e;

  typedef enum logic [1:0] {
    e_idle = 2'd0,
    e_resp = 2'd1,
    e_dump = 2'd2
  } bp_cfg_state_e;

endpackage

// File: rtl/bp_cfg_field_mux.sv
// Combinational field-ID lookup into a constant bp_proc_param_s entry.
// Unknown IDs return zero data with err set.
module bp_cfg_field_mux
  import bp_common_aviary_pkg::*;
#(
  parameter bp_proc_param_s proc_param_p     = '0,
  parameter int             data_width_p     = 64,
  parameter int             field_id_width_p = 6
) (
  input  logic [field_id_width_p-1:0] field,
  output logic [data_width_p-1:0]     data,
  output logic                        err
);

  logic [31:0] id_ext;
  logic [31:0] value;

  // Range check on the full-width ID so wide IDs never alias onto valid fields.
  assign id_ext = 32'(field);

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    value = '0;
    err   = 1'b0;
    if (id_ext >= 32'(bp_cfg_num_fields_gp)) begin
      err = 1'b1;
    end else begin
      case (bp_cfg_field_e'(id_ext[5:0]))
        e_field_num_core:                  value = proc_param_p.num_core;
        e_field_cc_x_dim:                  value = proc_param_p.cc_x_dim;
        e_field_cc_y_dim:                  value = proc_param_p.cc_y_dim;
        e_field_num_io:                    value = proc_param_p.num_io;
        e_field_num_cce:                   value = proc_param_p.num_cce;
        e_field_num_lce:                   value = proc_param_p.num_lce;
        e_field_asid_width:                value = proc_param_p.asid_width;
        e_field_vaddr_width:               value = proc_param_p.vaddr_width;
        e_field_paddr_width:               value = proc_param_p.paddr_width;
        e_field_branch_metadata_fwd_width: value = proc_param_p.branch_metadata_fwd_width;
        e_field_btb_tag_width:             value = proc_param_p.btb_tag_width;
        e_field_btb_idx_width:             value = proc_param_p.btb_idx_width;
        e_field_bht_idx_width:             value = proc_param_p.bht_idx_width;
        e_field_ghist_width:               value = proc_param_p.ghist_width;
        e_field_itlb_els:                  value = proc_param_p.itlb_els;
        e_field_dtlb_els:                  value = proc_param_p.dtlb_els;
        e_field_cce_pc_width:              value = proc_param_p.cce_pc_width;
        e_field_lce_sets:                  value = proc_param_p.lce_sets;
        e_field_lce_assoc:                 value = proc_param_p.lce_assoc;
        e_field_cce_block_width:           value = proc_param_p.cce_block_width;
        e_field_fe_queue_fifo_els:         value = proc_param_p.fe_queue_fifo_els;
        e_field_fe_cmd_fifo_els:           value = proc_param_p.fe_cmd_fifo_els;
        e_field_async_coh_clk:             value = proc_param_p.async_coh_clk;
        e_field_coh_noc_max_credits:       value = proc_param_p.coh_noc_max_credits;
        e_field_coh_noc_cord_width:        value = proc_param_p.coh_noc_cord_width;
        e_field_coh_noc_cid_width:         value = proc_param_p.coh_noc_cid_width;
        e_field_coh_noc_len_width:         value = proc_param_p.coh_noc_len_width;
        e_field_coh_noc_flit_width:        value = proc_param_p.coh_noc_flit_width;
        e_field_async_mem_clk:             value = proc_param_p.async_mem_clk;
        e_field_mem_noc_max_credits:       value = proc_param_p.mem_noc_max_credits;
        e_field_mem_noc_cord_width:        value = proc_param_p.mem_noc_cord_width;
        e_field_mem_noc_flit_width:        value = proc_param_p.mem_noc_flit_width;
        e_field_mem_noc_did_width:         value = proc_param_p.mem_noc_did_width;
        e_field_mem_noc_len_width:         value = proc_param_p.mem_noc_len_width;
        default:                           err   = 1'b1;
      endcase
    end
  end

  assign data = data_width_p'(value);

endmodule

// File: rtl/bp_cfg_param_responder.sv
// Read-side responder for one static processor parameter config: single-field
// reads and field dumps over valid/ready requests and valid/yumi responses.
module bp_cfg_param_responder
  import bp_common_aviary_pkg::*;
#(
  parameter bp_params_e cfg_p            = e_bp_single_core_cfg,
  parameter int         data_width_p     = 64,
  parameter int         field_id_width_p = 6
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        req_v_i,
  output logic                        req_ready_o,
  input  logic                        req_dump_i,
  input  logic [field_id_width_p-1:0] req_field_i,
  output logic                        resp_v_o,
  input  logic                        resp_yumi_i,
  output logic [field_id_width_p-1:0] resp_field_o,
  output logic [data_width_p-1:0]     resp_data_o,
  output logic                        resp_err_o,
  output logic                        resp_last_o
);

  localparam bp_proc_param_s proc_param_lp = all_cfgs_gp[cfg_p];
  localparam bit             inv_cfg_lp    = (cfg_p == e_bp_inv_cfg);
  localparam logic [field_id_width_p-1:0] last_field_lp =
    field_id_width_p'(bp_cfg_num_fields_gp - 1);

  bp_cfg_state_e                 state_r, state_n;
  // field_r doubles as the dump beat counter: it is the ID of the beat on the bus.
  logic [field_id_width_p-1:0]   field_r, field_n;
  logic [data_width_p-1:0]       data_r, data_n;
  logic                          err_r, err_n;
  logic                          last_r, last_n;

  logic [field_id_width_p-1:0]   lookup_field;
  logic [data_width_p-1:0]       mux_data, lookup_data;
  logic                          mux_err, lookup_err;
  logic                          req_fire, resp_fire, req_in_range;

  // During a dump the lookup pre-computes the next beat so it follows without a bubble.
  assign lookup_field = (state_r == e_dump) ? field_r + field_id_width_p'(1) : req_field_i;

  bp_cfg_field_mux #(
    .proc_param_p     (proc_param_lp),
    .data_width_p     (data_width_p),
    .field_id_width_p (field_id_width_p)
  ) field_mux (
    .field (lookup_field),
    .data  (mux_data),
    .err   (mux_err)
  );

  assign lookup_data  = inv_cfg_lp ? '0 : mux_data;
  assign lookup_err   = inv_cfg_lp | mux_err;
  assign req_in_range = (32'(req_field_i) < 32'(bp_cfg_num_fields_gp));

  assign resp_v_o    = (state_r != e_idle);
  assign req_ready_o = (state_r == e_idle) | ((state_r == e_resp) & resp_yumi_i);
  assign req_fire    = req_v_i & req_ready_o;
  assign resp_fire   = resp_v_o & resp_yumi_i;

  always_comb begin
    state_n = state_r;
    field_n = field_r;
    data_n  = data_r;
    err_n   = err_r;
    last_n  = last_r;
    case (state_r)
      e_idle, e_resp: begin
        if (req_fire) begin
          field_n = req_field_i;
          data_n  = lookup_data;
          err_n   = lookup_err;
          if (req_dump_i && req_in_range) begin
            state_n = e_dump;
            last_n  = (req_field_i == last_field_lp);
          end else begin
            state_n = e_resp;
            last_n  = 1'b1;
          end
        end else if (resp_fire) begin
          state_n = e_idle;
        end
      end
      e_dump: begin
        if (resp_fire) begin
          if (last_r) begin
            state_n = e_idle;
          end else begin
            field_n = lookup_field;
            data_n  = lookup_data;
            err_n   = lookup_err;
            last_n  = (lookup_field == last_field_lp);
          end
        end
      end
      default: state_n = e_idle;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_idle;
      field_r <= '0;
      data_r  <= '0;
      err_r   <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      field_r <= field_n;
      data_r  <= data_n;
      err_r   <= err_n;
      last_r  <= last_n;
    end
  end

  assign resp_field_o = field_r;
  assign resp_data_o  = data_r;
  assign resp_err_o   = err_r;
  assign resp_last_o  = last_r;

  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    resp_yumi_i |-> resp_v_o);

endmodule

// File: tb/tb_bp_cfg_param_responder.sv
// Bench for bp_cfg_param_responder: directed scenarios on single, dual and invalid
// configs, plus randomized traffic against a transaction-level queue model.
module tb_bp_cfg_param_responder;
  import bp_common_aviary_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_v [3];
  logic        req_ready [3];
  logic        req_dump [3];
  logic [5:0]  req_field [3];
  logic        resp_v [3];
  logic        resp_yumi [3];
  logic [5:0]  resp_field [3];
  logic [63:0] resp_data [3];
  logic        resp_err [3];
  logic        resp_last [3];

  int checks = 0;
  int errors = 0;

  // Expected single-core field values, in field-ID order.
  int unsigned single_tbl [34] = '{1, 1, 1, 1, 1, 2, 10, 39, 40, 36, 9, 6, 9, 2, 8, 8, 8,
                                   64, 8, 512, 8, 4, 0, 8, 4, 2, 3, 62, 0, 8, 4, 30, 3, 5};

  typedef struct {
    int          field;
    logic [63:0] data;
    logic        err;
    logic        last;
    logic        dump;
  } beat_t;

  always #5 clk = ~clk;

  bp_cfg_param_responder #(.cfg_p(e_bp_single_core_cfg)) u_single (
    .clk_i(clk), .reset_n_i(reset_n),
    .req_v_i(req_v[0]), .req_ready_o(req_ready[0]), .req_dump_i(req_dump[0]),
    .req_field_i(req_field[0]), .resp_v_o(resp_v[0]), .resp_yumi_i(resp_yumi[0]),
    .resp_field_o(resp_field[0]), .resp_data_o(resp_data[0]),
    .resp_err_o(resp_err[0]), .resp_last_o(resp_last[0]));

  bp_cfg_param_responder #(.cfg_p(e_bp_dual_core_cfg)) u_dual (
    .clk_i(clk), .reset_n_i(reset_n),
    .req_v_i(req_v[1]), .req_ready_o(req_ready[1]), .req_dump_i(req_dump[1]),
    .req_field_i(req_field[1]), .resp_v_o(resp_v[1]), .resp_yumi_i(resp_yumi[1]),
    .resp_field_o(resp_field[1]), .resp_data_o(resp_data[1]),
    .resp_err_o(resp_err[1]), .resp_last_o(resp_last[1]));

  bp_cfg_param_responder #(.cfg_p(e_bp_inv_cfg)) u_inv (
    .clk_i(clk), .reset_n_i(reset_n),
    .req_v_i(req_v[2]), .req_ready_o(req_ready[2]), .req_dump_i(req_dump[2]),
    .req_field_i(req_field[2]), .resp_v_o(resp_v[2]), .resp_yumi_i(resp_yumi[2]),
    .resp_field_o(resp_field[2]), .resp_data_o(resp_data[2]),
    .resp_err_o(resp_err[2]), .resp_last_o(resp_last[2]));

  // Reference: {err, data} for dut d (0 single, 1 dual, 2 invalid) and field id.
  function automatic logic [64:0] ref_beat(input int d, input int id);
    int unsigned v;
    if (d == 2 || id >= 34) return {1'b1, 64'd0};
    v = single_tbl[id];
    if (d == 1) begin
      case (id)
        0, 1, 4: v = 2;
        5:       v = 4;
        default: ;
      endcase
    end
    return {1'b0, 64'(v)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input int d, input logic dump, input int field);
    tick();
    req_v[d]     = 1'b1;
    req_dump[d]  = dump;
    req_field[d] = 6'(field);
    tick();
    req_v[d]    = 1'b0;
    req_dump[d] = 1'b0;
  endtask

  task automatic consume(input int d);
    resp_yumi[d] = 1'b1;
    tick();
    resp_yumi[d] = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({resp_v[d], resp_err[d], resp_last[d], resp_field[d], resp_data[d], req_ready[d]}
          !== {1'b0, 1'b0, 1'b0, 6'd0, 64'd0, 1'b1}) begin
        errors++;
        $display("FAIL reset_state dut%0d: got v=%b err=%b last=%b field=%0d data=%0h ready=%b",
                 d, resp_v[d], resp_err[d], resp_last[d], resp_field[d], resp_data[d], req_ready[d]);
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    int ids [3] = '{0, 7, 17};
    logic [63:0] exp [3] = '{64'd1, 64'd39, 64'd64};
    tick();
    req_v[0] = 1'b1; req_dump[0] = 1'b0; req_field[0] = 6'(ids[0]);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i < 2) req_field[0] = 6'(ids[i+1]);
      else       req_v[0] = 1'b0;
      resp_yumi[0] = 1'b1;
      @(negedge clk);
      checks++;
      if ({resp_v[0], resp_field[0], resp_data[0], resp_err[0], resp_last[0], req_ready[0]}
          !== {1'b1, 6'(ids[i]), exp[i], 1'b0, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL b2b_beat%0d: got v=%b field=%0d data=%0d err=%b last=%b ready=%b want field=%0d data=%0d",
                 i, resp_v[0], resp_field[0], resp_data[0], resp_err[0], resp_last[0], req_ready[0],
                 ids[i], exp[i]);
      end
    end
    tick();
    resp_yumi[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got resp_v=%b want 0", resp_v[0]);
    end
  endtask

  task automatic test_out_of_range();
    send_req(0, 1'b0, 40);
    @(negedge clk);
    checks++;
    if ({resp_v[0], resp_field[0], resp_data[0], resp_err[0], resp_last[0]}
        !== {1'b1, 6'd40, 64'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL oor_read: got v=%b field=%0d data=%0h err=%b last=%b want 1 40 0 1 1",
               resp_v[0], resp_field[0], resp_data[0], resp_err[0], resp_last[0]);
    end
    tick();
    consume(0);
  endtask

  task automatic test_dump();
    logic [63:0] exp [3] = '{64'd30, 64'd3, 64'd5};
    send_req(0, 1'b1, 31);
    resp_yumi[0] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if ({resp_v[0], resp_field[0], resp_data[0], resp_err[0], resp_last[0], req_ready[0]}
          !== {1'b1, 6'(31 + j), exp[j], 1'b0, (j == 2), 1'b0}) begin
        errors++;
        $display("FAIL dump_beat%0d: got v=%b field=%0d data=%0d err=%b last=%b ready=%b want field=%0d data=%0d",
                 j, resp_v[0], resp_field[0], resp_data[0], resp_err[0], resp_last[0], req_ready[0],
                 31 + j, exp[j]);
      end
      tick();
    end
    resp_yumi[0] = 1'b0;
    @(negedge clk);
    checks++;
    if ({resp_v[0], req_ready[0]} !== 2'b01) begin
      errors++;
      $display("FAIL dump_end: got v=%b ready=%b want v=0 ready=1", resp_v[0], req_ready[0]);
    end
  endtask

  task automatic test_backpressure();
    send_req(1, 1'b0, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({resp_v[1], resp_field[1], resp_data[1], req_ready[1]} !== {1'b1, 6'd1, 64'd2, 1'b0}) begin
        errors++;
        $display("FAIL hold_cycle%0d: got v=%b field=%0d data=%0d ready=%b want 1 1 2 0",
                 k, resp_v[1], resp_field[1], resp_data[1], req_ready[1]);
      end
      tick();
    end
    req_v[1] = 1'b1; req_field[1] = 6'd0; resp_yumi[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL yumi_cycle_ready: got %b want 1", req_ready[1]);
    end
    tick();
    req_v[1] = 1'b0; resp_yumi[1] = 1'b0;
    @(negedge clk);
    checks++;
    if ({resp_v[1], resp_field[1], resp_data[1]} !== {1'b1, 6'd0, 64'd2}) begin
      errors++;
      $display("FAIL hold_next_req: got v=%b field=%0d data=%0d want 1 0 2",
               resp_v[1], resp_field[1], resp_data[1]);
    end
    tick();
    consume(1);
  endtask

  task automatic test_reset_mid_dump();
    logic [64:0] rb;
    send_req(1, 1'b1, 0);
    resp_yumi[1] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      rb = ref_beat(1, j);
      checks++;
      if ({resp_v[1], resp_field[1], resp_data[1], resp_err[1], resp_last[1]}
          !== {1'b1, 6'(j), rb[63:0], rb[64], 1'b0}) begin
        errors++;
        $display("FAIL dual_dump_beat%0d: got v=%b field=%0d data=%0d err=%b last=%b want data=%0d",
                 j, resp_v[1], resp_field[1], resp_data[1], resp_err[1], resp_last[1], rb[63:0]);
      end
      tick();
    end
    resp_yumi[1] = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({resp_v[1], resp_field[1], resp_data[1], resp_err[1], resp_last[1]} !== {1'b0, 6'd0, 64'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: got v=%b field=%0d data=%0h err=%b last=%b want all 0",
               resp_v[1], resp_field[1], resp_data[1], resp_err[1], resp_last[1]);
    end
    @(negedge clk);
    reset_n = 1'b1;
    send_req(1, 1'b0, 0);
    @(negedge clk);
    checks++;
    if ({resp_v[1], resp_field[1], resp_data[1], resp_err[1], resp_last[1]} !== {1'b1, 6'd0, 64'd2, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL post_reset_read: got v=%b field=%0d data=%0d err=%b last=%b want 1 0 2 0 1",
               resp_v[1], resp_field[1], resp_data[1], resp_err[1], resp_last[1]);
    end
    tick();
    consume(1);
  endtask

  task automatic test_invalid_cfg();
    send_req(2, 1'b0, 0);
    @(negedge clk);
    checks++;
    if ({resp_v[2], resp_field[2], resp_data[2], resp_err[2], resp_last[2]} !== {1'b1, 6'd0, 64'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL inv_cfg_read: got v=%b field=%0d data=%0h err=%b last=%b want 1 0 0 1 1",
               resp_v[2], resp_field[2], resp_data[2], resp_err[2], resp_last[2]);
    end
    tick();
    consume(2);
  endtask

  task automatic test_random(input int d, input int cycles);
    beat_t       exp_q [$];
    beat_t       b;
    logic [64:0] rb;
    logic        exp_ready;
    logic        took = 1'b1;
    int          id;
    for (int c = 0; c < cycles + 80; c++) begin
      tick();
      if (!req_v[d] || took) begin
        if (c < cycles) begin
          req_v[d]     = 1'($urandom_range(0, 1));
          req_dump[d]  = ($urandom_range(0, 3) == 0);
          req_field[d] = req_dump[d] ? 6'($urandom_range(20, 40)) : 6'($urandom_range(0, 40));
        end else begin
          req_v[d] = 1'b0;
        end
      end
      resp_yumi[d] = resp_v[d] && (c >= cycles || $urandom_range(0, 2) != 0);
      @(negedge clk);
      checks++;
      if (resp_v[d] !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL rnd%0d_valid c=%0d: got %b want %b", d, c, resp_v[d], exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        b = exp_q[0];
        checks++;
        if ({resp_field[d], resp_data[d], resp_err[d], resp_last[d]} !== {6'(b.field), b.data, b.err, b.last}) begin
          errors++;
          $display("FAIL rnd%0d_beat c=%0d: got field=%0d data=%0d err=%b last=%b want field=%0d data=%0d err=%b last=%b",
                   d, c, resp_field[d], resp_data[d], resp_err[d], resp_last[d], b.field, b.data, b.err, b.last);
        end
      end
      exp_ready = (exp_q.size() == 0) ? 1'b1 : (exp_q[0].dump ? 1'b0 : resp_yumi[d]);
      checks++;
      if (req_ready[d] !== exp_ready) begin
        errors++;
        $display("FAIL rnd%0d_ready c=%0d: got %b want %b", d, c, req_ready[d], exp_ready);
      end
      took = req_v[d] && exp_ready;
      if (exp_q.size() != 0 && resp_yumi[d]) void'(exp_q.pop_front());
      if (took) begin
        id = int'(req_field[d]);
        if (req_dump[d] && id < 34) begin
          for (int k = id; k < 34; k++) begin
            rb = ref_beat(d, k);
            exp_q.push_back('{field: k, data: rb[63:0], err: rb[64], last: (k == 33), dump: 1'b1});
          end
        end else begin
          rb = ref_beat(d, id);
          exp_q.push_back('{field: id, data: rb[63:0], err: rb[64], last: 1'b1, dump: 1'b0});
        end
      end
    end
    tick();
    req_v[d] = 1'b0; req_dump[d] = 1'b0; resp_yumi[d] = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rnd%0d_drain: got %0d beats outstanding want 0", d, exp_q.size());
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      req_v[d] = 1'b0; req_dump[d] = 1'b0; req_field[d] = '0; resp_yumi[d] = 1'b0;
    end
    test_reset();
    test_back_to_back();
    test_out_of_range();
    test_dump();
    test_backpressure();
    test_reset_mid_dump();
    test_invalid_cfg();
    for (int d = 0; d < 3; d++) test_random(d, 300);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no completion want finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
